shift_right_seq_unit: RTL and testbench
=======================================

# shift_right_seq_unit

Parametrised, registered successor to the combinational 8-bit shift-right unit. It loads a WIDTH-bit operand, then shifts it right by a programmable amount, one bit per clock. Four modes are supported: logical, rotate, rotate-through-carry and arithmetic. A start/busy/done handshake lets the datapath controller issue multi-bit shifts without an external counter.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- AMT_W, $clog2(WIDTH)+1, width of the shift-amount port
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only when busy=0
- sel1, sel0  input  1 each  mode: 00 logical, 01 rotate, 10 rotate-through-carry, 11 arithmetic
- amt  input  AMT_W  number of single-bit shift steps (0..2^AMT_W-1)
- x  input  WIDTH  operand
- cin  input  1  carry-in, used only in mode 10
- f  output  WIDTH  working/result register
- cout  output  1  carry/last-bit-out register
- busy  output  1  high while shift steps remain
- done  output  1  one-cycle pulse: result valid

## Operation
- States: IDLE, SHIFT, DONE.
- In IDLE or DONE, start=1 at an edge does the following:
  - Latch the mode, amt (as a counter) and cin.
  - Load f<=x.
  - Load cout<=cin if mode 10, else cout<=0.
  - Go to SHIFT if amt≠0, else go to DONE.
- In SHIFT, each edge performs one step and decrements the counter. The MSB fill per mode:
  - 00: f<={0, f[W-1:1]}, cout<=f[0].
  - 01: f<={f[0], f[W-1:1]}, cout<=f[0].
  - 10: f<={cout, f[W-1:1]}, cout<=f[0]. This is a (WIDTH+1)-bit ring.
  - 11: f<={f[W-1], f[W-1:1]}, cout<=f[0].
- On the edge that performs the final step (counter 1→0), go to DONE.
- DONE lasts one cycle, then goes to IDLE. start in DONE is accepted exactly as in IDLE.
- No clamping of amt:
  - Logical with amt≥WIDTH gives f=0.
  - Rotate wraps modulo WIDTH.
  - Through-carry wraps modulo WIDTH+1.
- start while busy=1 is ignored. Changes to sel, amt, x or cin during SHIFT have no effect.
- f and cout hold their final values after DONE until the next accepted start.
- Reset (rst_n=0, any time, including mid-SHIFT):
  - Immediately f=0, cout=0, busy=0, done=0, state IDLE.
  - The counter and latched mode are cleared. No done follows for the aborted operation.

## Timing
- E0 is the edge accepting start.
- amt=n>0:
  - busy=1 from after E0 through after E(n-1), i.e. n cycles.
  - Step k occurs at edge Ek.
  - done=1 and busy=0 for the cycle after En. f/cout are final from that cycle.
- amt=0: busy stays 0. done=1 for the cycle after E0, with f=x and cout per load rule.
- Back-to-back: start during the done cycle is accepted at that edge. done drops, and busy rises the next cycle (if amt≠0).
- busy and done are never high simultaneously.
- f shows intermediate values during SHIFT; consumers must qualify with done.
- Outputs are registers only. No combinational path from inputs to outputs.

## Test plan
- Mode 00, x=8'b1001_0110, amt=3 -> busy high 3 cycles, then done; f=8'b0001_0010, cout=1.
- Mode 11, x=8'b1000_0001, amt=2 -> f=8'b1110_0000, cout=0. Second start pulsed mid-shift is ignored (no extra done).
- Mode 01, x=8'b0000_0001, amt=9 -> 9 busy cycles; f=8'b1000_0000, cout=1 (wrap-around).
- Mode 10, x=8'b0000_0001, cin=1, amt=2 -> f=8'b1100_0000, cout=0. Then start in the done cycle with amt=0, x=8'hA5 -> done on the next cycle, busy stays 0, f=8'hA5, cout=cin.
- Mode 00, amt=12 (WIDTH=8), x=8'hFF -> f=8'h00, cout=0 after 12 busy cycles.
- rst_n driven low after 2 of 5 steps -> f=0, cout=0, busy=0, done=0 asynchronously. After release, no done; a fresh start operates normally.

Source files
------------

// File: rtl/shift_right_seq_unit.sv
// rtl/shift_right_seq_unit.sv - sequential right shifter, one bit per clock, four fill modes
//
// Purpose: loads a WIDTH-bit operand on an accepted start, then shifts it right
// by a latched amount, one step per clock. It signals busy while steps remain,
// and it pulses done for one cycle when the result is valid.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      request; accepted whenever no shift is in progress (IDLE or DONE)
//   sel1,sel0  mode: 00 logical, 01 rotate, 10 rotate-through-carry, 11 arithmetic
//   amt        number of single-bit steps, latched at start
//   x          operand, loaded into f at start
//   cin        carry-in, seeds cout in rotate-through-carry mode
//   f          working/result register
//   cout       last bit shifted out (carry bit of the ring in mode 10)
//   busy       high while shift steps remain
//   done       one-cycle pulse, f/cout valid
module shift_right_seq_unit #(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sel1,
  input  logic             sel0,
  input  logic [AMT_W-1:0] amt,
  input  logic [WIDTH-1:0] x,
  input  logic             cin,
  output logic [WIDTH-1:0] f,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [1:0] MODE_LOGICAL = 2'b00;
  localparam logic [1:0] MODE_ROTATE  = 2'b01;
  localparam logic [1:0] MODE_RCARRY  = 2'b10;
  localparam logic [1:0] MODE_ARITH   = 2'b11;

  localparam logic [AMT_W-1:0] CNT_ONE = AMT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [1:0]       mode_q,  mode_d;
  logic [AMT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] f_q,     f_d;
  logic             cout_q,  cout_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;

  logic             accept;
  logic             fill_bit;
  logic [1:0]       mode_in;

  assign mode_in = {sel1, sel0};

  // start is honoured in IDLE and in the DONE cycle, never during SHIFT.
  assign accept = start && (state_q != ST_SHIFT);

  // Bit entering at the MSB on a shift step, chosen by the latched mode.
  always_comb begin
    fill_bit = 1'b0;
    case (mode_q)
      MODE_LOGICAL: fill_bit = 1'b0;
      MODE_ROTATE:  fill_bit = f_q[0];
      MODE_RCARRY:  fill_bit = cout_q;      // WIDTH+1-bit ring through cout
      MODE_ARITH:   fill_bit = f_q[WIDTH-1];
      default:      fill_bit = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    f_d     = f_q;
    cout_d  = cout_q;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
      ST_SHIFT: begin
        f_d    = {fill_bit, f_q[WIDTH-1:1]};
        cout_d = f_q[0];
        cnt_d  = cnt_q - CNT_ONE;
        // SHIFT is only entered with a non-zero count, so 1 marks the last step.
        if (cnt_q == CNT_ONE) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A new request overrides the DONE->IDLE return so back-to-back ops lose no cycle.
    if (accept) begin
      mode_d  = mode_in;
      cnt_d   = amt;
      f_d     = x;
      cout_d  = (mode_in == MODE_RCARRY) ? cin : 1'b0;
      state_d = (amt != '0) ? ST_SHIFT : ST_DONE;
    end
  end

  // busy/done are registered copies of the next state so the outputs come
  // straight from flops and can never be high together.
  assign busy_d = (state_d == ST_SHIFT);
  assign done_d = (state_d == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_LOGICAL;
      cnt_q   <= '0;
      f_q     <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      f_q     <= f_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign f    = f_q;
  assign cout = cout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_shift_right_seq_unit.sv
// tb/tb_shift_right_seq_unit.sv - scoreboard bench for shift_right_seq_unit
module tb_shift_right_seq_unit;

  localparam int WIDTH = 8;
  localparam int AMT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             sel1;
  logic             sel0;
  logic [AMT_W-1:0] amt;
  logic [WIDTH-1:0] x;
  logic             cin;
  logic [WIDTH-1:0] f;
  logic             cout;
  logic             busy;
  logic             done;

  shift_right_seq_unit #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sel1  (sel1),
    .sel0  (sel0),
    .amt   (amt),
    .x     (x),
    .cin   (cin),
    .f     (f),
    .cout  (cout),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] ef;
    logic             ec;
    logic [31:0]      nbusy;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   busy_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [WIDTH:0] model(input logic [1:0] m, input int n,
                                           input logic [WIDTH-1:0] xv, input logic c);
    logic [WIDTH-1:0] r;
    logic             co;
    logic             fill;
    r  = xv;
    co = (m == 2'b10) ? c : 1'b0;
    for (int i = 0; i < n; i++) begin
      case (m)
        2'b00:   fill = 1'b0;
        2'b01:   fill = r[0];
        2'b10:   fill = co;
        default: fill = r[WIDTH-1];
      endcase
      co = r[0];
      r  = {fill, r[WIDTH-1:1]};
    end
    return {co, r};
  endfunction

  // Monitor: counts busy cycles per operation and scores each done pulse.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (busy || done) chk("busy_done_excl", {31'd0, busy & done}, 32'd0);
      if (done) begin
        chk("sb_nonempty", {31'd0, sb.size() > 0}, 32'd1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("f", {24'd0, f}, {24'd0, e.ef});
          chk("cout", {31'd0, cout}, {31'd0, e.ec});
          chk("busy_cycles", busy_cnt, e.nbusy);
        end
        busy_cnt = 0;
      end
    end
  end

  // Called mid-cycle; the request is presented for exactly one rising edge.
  task automatic do_start(input logic [1:0] m, input int a, input logic [WIDTH-1:0] xv,
                          input logic c, input logic [WIDTH-1:0] ef, input logic ec);
    logic will_accept;
    exp_t e;
    sel1  = m[1];
    sel0  = m[0];
    amt   = AMT_W'(a);
    x     = xv;
    cin   = c;
    start = 1'b1;
    will_accept = !busy;
    @(posedge clk);
    if (will_accept) begin
      e.ef    = ef;
      e.ec    = ec;
      e.nbusy = a;
      sb.push_back(e);
    end
    #1 start = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb.size(), 32'd0);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 100);
    chk("wait_done", {31'd0, done}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH:0] mr;
    logic [1:0]     rm;
    int             ra;
    logic [WIDTH-1:0] rx;
    logic           rc;

    rst_n = 1'b0;
    start = 1'b0;
    sel1  = 1'b0;
    sel0  = 1'b0;
    amt   = '0;
    x     = '0;
    cin   = 1'b0;
    #3;
    chk("rst_f",    {24'd0, f},     32'd0);
    chk("rst_cout", {31'd0, cout},  32'd0);
    chk("rst_busy", {31'd0, busy},  32'd0);
    chk("rst_done", {31'd0, done},  32'd0);
    #9 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Logical shift by 3.
    do_start(2'b00, 3, 8'b1001_0110, 1'b0, 8'b0001_0010, 1'b1);
    drain();

    // Arithmetic by 2, with an ignored start during the shift.
    @(negedge clk);
    do_start(2'b11, 2, 8'b1000_0001, 1'b0, 8'b1110_0000, 1'b0);
    do_start(2'b00, 1, 8'hFF, 1'b1, 8'h00, 1'b0);
    drain();
    repeat (4) @(negedge clk);

    // Rotate wraps modulo WIDTH.
    do_start(2'b01, 9, 8'b0000_0001, 1'b0, 8'b1000_0000, 1'b1);
    drain();

    // Through-carry, then back-to-back zero-amount start in the done cycle.
    @(negedge clk);
    do_start(2'b10, 2, 8'b0000_0001, 1'b1, 8'b1100_0000, 1'b0);
    wait_done();
    do_start(2'b10, 0, 8'hA5, 1'b1, 8'hA5, 1'b1);
    drain();
    chk("b2b_busy_low", {31'd0, busy}, 32'd0);

    // Logical with amt beyond WIDTH clears everything.
    @(negedge clk);
    do_start(2'b00, 12, 8'hFF, 1'b0, 8'h00, 1'b0);
    drain();

    // Asynchronous reset after 2 of 5 steps.
    @(negedge clk);
    do_start(2'b00, 5, 8'hB7, 1'b0, 8'h05, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_f",    {24'd0, f},    32'd0);
    chk("mid_rst_cout", {31'd0, cout}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (8) @(negedge clk);
    do_start(2'b11, 3, 8'h96, 1'b0, 8'hF2, 1'b1);
    drain();

    // Random operations checked against the reference model.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      rm = 2'($urandom_range(0, 3));
      ra = $urandom_range(0, 15);
      rx = 8'($urandom);
      rc = 1'($urandom);
      mr = model(rm, ra, rx, rc);
      do_start(rm, ra, rx, rc, mr[WIDTH-1:0], mr[WIDTH]);
      drain();
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
